// File: rtl/led_pkg.sv
// Shared types and constants for the LED chaser rate controller.
// Defaults assume a 125 MHz system clock.
package led_pkg;

  localparam int unsigned LEVEL_W       = 3;
  localparam int unsigned CNT_W         = 32;
  localparam int unsigned CLK_HZ        = 125_000_000;
  localparam int unsigned DEBOUNCE_10MS = 1_250_000;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_UP   = 2'd1,
    LVL_DOWN = 2'd2
  } lvl_op_e;

  // Opposing presses cancel, and a press against a rail is a no-op so it
  // never disturbs the running period.
  function automatic lvl_op_e level_op(input logic fast, input logic slow,
                                       input logic at_max, input logic at_min);
    if (fast && !slow && !at_max) return LVL_UP;
    if (slow && !fast && !at_min) return LVL_DOWN;
    return LVL_HOLD;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronise and debounce one raw push-button; emits a registered one-cycle
// pulse on each accepted press (released-to-pressed transition).
module btn_debounce
  import led_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic stable_o,
  output logic press_o
);

  logic sync1_q, sync2_q;
  logic stable_q, stable_d;
  logic stable_dly_q;
  logic press_q;
  cnt_t cnt_q, cnt_d;

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of process order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      press_q      <= stable_q & ~stable_dly_q;
      cnt_q        <= cnt_d;
    end
  end

  // NOTE: every variable gets a default before any branch; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q >= cnt_t'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + cnt_t'(1);
      end
    end
  end

  assign stable_o = stable_q;
  assign press_o  = press_q;

endmodule

// File: rtl/led_tick_gen.sv
// Programmable-rate tick source for the LED chaser: debounced faster/slower/
// pause buttons select a period of BASE_PERIOD >> level and gate ticking.
module led_tick_gen #(
  parameter int unsigned BASE_PERIOD     = led_pkg::CLK_HZ,
  parameter int unsigned NUM_LEVELS      = 8,
  parameter int unsigned LEVEL_W         = led_pkg::LEVEL_W,
  parameter int unsigned DEBOUNCE_CYCLES = led_pkg::DEBOUNCE_10MS
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               btn_fast_i,
  input  logic               btn_slow_i,
  input  logic               btn_pause_i,
  output logic               tick_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic               paused_o
);
  import led_pkg::*;

  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(NUM_LEVELS - 1);

  logic       fast_press, slow_press, pause_press;
  // Debounced button levels are not needed here; only press pulses are.
  logic [2:0] btn_stable_unused;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_fast (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .btn_i    (btn_fast_i),
    .stable_o (btn_stable_unused[0]),
    .press_o  (fast_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_slow (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .btn_i    (btn_slow_i),
    .stable_o (btn_stable_unused[1]),
    .press_o  (slow_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pause (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .btn_i    (btn_pause_i),
    .stable_o (btn_stable_unused[2]),
    .press_o  (pause_press)
  );

  logic [LEVEL_W-1:0] level_q, level_d;
  logic               paused_q, paused_d;
  logic               tick_q, tick_d;
  cnt_t               cnt_q, cnt_d;
  cnt_t               period;
  lvl_op_e            lvl_op;
  logic               level_chg;

  assign lvl_op    = level_op(fast_press, slow_press,
                              level_q == LEVEL_MAX, level_q == '0);
  assign level_chg = (lvl_op != LVL_HOLD);
  assign period    = cnt_t'(BASE_PERIOD) >> level_q;

  always_comb begin
    level_d = level_q;
    case (lvl_op)
      LVL_UP:   level_d = level_q + LEVEL_W'(1);
      LVL_DOWN: level_d = level_q - LEVEL_W'(1);
      default:  level_d = level_q;
    endcase
  end

  // The counter update looks at paused_q, so a pause toggle landing on the
  // terminal count still lets that cycle's tick through.
  always_comb begin
    paused_d = paused_q ^ pause_press;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    if (level_chg) begin
      cnt_d = '0;
    end else if (!paused_q) begin
      if (cnt_q >= period - cnt_t'(1)) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q  <= '0;
      paused_q <= 1'b0;
      tick_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      level_q  <= level_d;
      paused_q <= paused_d;
      tick_q   <= tick_d;
      cnt_q    <= cnt_d;
    end
  end

  assign tick_o   = tick_q;
  assign level_o  = level_q;
  assign paused_o = paused_q;

endmodule

// File: tb/tb_led_tick_gen.sv
// Directed bench for led_tick_gen with a short base period and debounce.
module tb_led_tick_gen;

  localparam int unsigned BASE_PERIOD     = 256;
  localparam int unsigned NUM_LEVELS      = 8;
  localparam int unsigned LEVEL_W         = 3;
  localparam int unsigned DEBOUNCE_CYCLES = 4;
  // Raw edge -> sync(2) -> debounce(D) -> press flop(1) -> level/pause flop(1)
  localparam int unsigned PRESS_LAT       = DEBOUNCE_CYCLES + 4;

  logic               clk_i       = 1'b0;
  logic               rst_ni      = 1'b0;
  logic               btn_fast_i  = 1'b0;
  logic               btn_slow_i  = 1'b0;
  logic               btn_pause_i = 1'b0;
  logic               tick_o;
  logic [LEVEL_W-1:0] level_o;
  logic               paused_o;

  led_tick_gen #(
    .BASE_PERIOD     (BASE_PERIOD),
    .NUM_LEVELS      (NUM_LEVELS),
    .LEVEL_W         (LEVEL_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .btn_fast_i  (btn_fast_i),
    .btn_slow_i  (btn_slow_i),
    .btn_pause_i (btn_pause_i),
    .tick_o      (tick_o),
    .level_o     (level_o),
    .paused_o    (paused_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned        total = 0;
  int unsigned        bad   = 0;
  int unsigned        cyc   = 0;
  int unsigned        tick_cyc[$];
  int unsigned        lvl_chg_cyc   = 0;
  int unsigned        pause_chg_cyc = 0;
  int unsigned        last_tick     = 0;
  logic [LEVEL_W-1:0] lvl_prev      = '0;
  logic               paused_prev   = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (tick_o === 1'b1) tick_cyc.push_back(cyc);
    if (level_o !== lvl_prev) begin
      lvl_chg_cyc = cyc;
      lvl_prev    = level_o;
    end
    if (paused_o !== paused_prev) begin
      pause_chg_cyc = cyc;
      paused_prev   = paused_o;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_i);
    #1;
  endtask

  task automatic press(input logic f, input logic s, input logic p,
                       input int hold, input int gap, input int reps);
    for (int r = 0; r < reps; r++) begin
      btn_fast_i  = f;
      btn_slow_i  = s;
      btn_pause_i = p;
      cycles(hold);
      btn_fast_i  = 1'b0;
      btn_slow_i  = 1'b0;
      btn_pause_i = 1'b0;
      cycles(gap);
    end
  endtask

  // Next logged tick must land exactly gap cycles after ref_c.
  task automatic expect_tick(input string name, input int unsigned ref_c, input int unsigned gap);
    int unsigned t;
    while (tick_cyc.size() == 0 && cyc < ref_c + gap + 16) cycles(1);
    total++;
    if (tick_cyc.size() == 0) begin
      bad++;
      $display("FAIL %s: no tick by cycle %0d, expected one %0d cycles after %0d",
               name, cyc, gap, ref_c);
    end else begin
      total--;
      t = tick_cyc.pop_front();
      last_tick = t;
      check(name, t - ref_c, gap);
    end
  endtask

  task automatic check_spacing(input string name, input int unsigned gap);
    int unsigned t0, t1, lim;
    tick_cyc.delete();
    lim = cyc + 3 * gap + 16;
    while (tick_cyc.size() < 2 && cyc < lim) cycles(1);
    total++;
    if (tick_cyc.size() < 2) begin
      bad++;
      $display("FAIL %s: saw %0d ticks by cycle %0d, expected 2 spaced %0d",
               name, tick_cyc.size(), cyc, gap);
    end else begin
      total--;
      t0 = tick_cyc.pop_front();
      t1 = tick_cyc.pop_front();
      last_tick = t1;
      check(name, t1 - t0, gap);
    end
  endtask

  typedef struct {
    string              name;
    logic               fast;
    logic               slow;
    logic               pause;
    int                 hold;
    int                 gap;
    int                 reps;
    logic [LEVEL_W-1:0] exp_level;
    logic               exp_paused;
    int unsigned        exp_gap;     // 0: skip tick spacing check
  } vec_t;

  vec_t vecs[8];

  initial begin
    int unsigned rel, c0, t0;

    vecs[0] = '{"hold100",   1'b1, 1'b0, 1'b0, 100, 12, 1, 3'd2, 1'b0, 64};
    vecs[1] = '{"glitch",    1'b1, 1'b0, 1'b0,   3,  2, 6, 3'd2, 1'b0,  0};
    vecs[2] = '{"sat_up",    1'b1, 1'b0, 1'b0,   6,  6, 9, 3'd7, 1'b0,  2};
    vecs[3] = '{"down8",     1'b0, 1'b1, 1'b0,   6,  6, 8, 3'd0, 1'b0,  0};
    vecs[4] = '{"down_sat",  1'b0, 1'b1, 1'b0,   6,  6, 1, 3'd0, 1'b0,  0};
    vecs[5] = '{"up3",       1'b1, 1'b0, 1'b0,   6,  6, 3, 3'd3, 1'b0, 32};
    vecs[6] = '{"both",      1'b1, 1'b1, 1'b0,   6,  6, 1, 3'd3, 1'b0, 32};
    vecs[7] = '{"down3",     1'b0, 1'b1, 1'b0,   6,  6, 3, 3'd0, 1'b0, 256};

    // Reset state and free-running ticks at level 0
    cycles(3);
    check("rst_tick", tick_o, 0);
    check("rst_level", level_o, 0);
    check("rst_paused", paused_o, 0);
    rst_ni = 1'b1;
    rel = cyc;
    tick_cyc.delete();
    expect_tick("tick_256", rel, 256);
    expect_tick("tick_512", rel, 512);
    expect_tick("tick_768", rel, 768);
    check("lvl0_level", level_o, 0);
    check("lvl0_paused", paused_o, 0);

    // Single fast press: latency and counter restart
    tick_cyc.delete();
    c0 = cyc;
    press(1'b1, 1'b0, 1'b0, 12, 0, 1);
    check("fast_level", level_o, 1);
    check("fast_latency", lvl_chg_cyc - c0, PRESS_LAT);
    expect_tick("fast_tick1", lvl_chg_cyc, 128);
    expect_tick("fast_tick2", lvl_chg_cyc, 256);

    for (int i = 0; i < 8; i++) begin
      press(vecs[i].fast, vecs[i].slow, vecs[i].pause,
            vecs[i].hold, vecs[i].gap, vecs[i].reps);
      cycles(16);
      check({vecs[i].name, "_level"}, level_o, vecs[i].exp_level);
      check({vecs[i].name, "_paused"}, paused_o, vecs[i].exp_paused);
      if (vecs[i].exp_gap != 0) check_spacing({vecs[i].name, "_gap"}, vecs[i].exp_gap);
    end

    // Saturated slow press at level 0 must not restart the period
    t0 = last_tick;
    tick_cyc.delete();
    press(1'b0, 1'b1, 1'b0, 6, 6, 1);
    expect_tick("sat_no_restart", t0, 256);

    // Pause lands on the edge where the counter holds 100
    t0 = last_tick;
    while (cyc < t0 + 101 - PRESS_LAT) cycles(1);
    press(1'b0, 1'b0, 1'b1, 6, 6, 1);
    check("pause_on", paused_o, 1);
    check("pause_at_cnt100", pause_chg_cyc - t0, 101);
    tick_cyc.delete();
    cycles(1000);
    check("paused_no_ticks", tick_cyc.size(), 0);
    check("still_paused", paused_o, 1);
    c0 = cyc;
    press(1'b0, 1'b0, 1'b1, 6, 6, 1);
    check("pause_off", paused_o, 0);
    check("resume_latency", pause_chg_cyc - c0, PRESS_LAT);
    expect_tick("resume_tick", pause_chg_cyc, 155);

    // Asynchronous reset mid-period at level 3 while paused
    press(1'b1, 1'b0, 1'b0, 6, 6, 3);
    press(1'b0, 1'b0, 1'b1, 6, 6, 1);
    cycles(37);
    check("pre_rst_level", level_o, 3);
    check("pre_rst_paused", paused_o, 1);
    rst_ni = 1'b0;
    #2;
    check("async_rst_tick", tick_o, 0);
    check("async_rst_level", level_o, 0);
    check("async_rst_paused", paused_o, 0);
    cycles(3);
    rst_ni = 1'b1;
    rel = cyc;
    tick_cyc.delete();
    expect_tick("post_rst_tick", rel, 256);
    check("post_rst_level", level_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
